imem_sync: RTL and testbench

- Parametrised, synchronous instruction memory for the pipelined RV32I fetch stage.
- Replaces the combinational write-through instruction RAM with a clocked array. It has a dedicated program-load port and a boot FSM that holds fetch off until loading completes.
- The registered fetch output supports stall, flush and fault handling. It feeds the IF/ID register directly.

---
 rtl/imem_sync.sv | 80 ++++++++
 tb/tb_imem_sync.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
// imem_sync: synchronous RV32I instruction memory with program-load port, boot FSM
// and a registered fetch output that supports stall, flush and fault reporting.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ld_we, ld_addr, ld_data, ld_done program-load port (honoured only in LOAD)
//   ld_err                           sticky: load attempted after boot
//   ready                            high once the FSM has reached RUN
//   fetch_en, pc, stall, flush       fetch request and pipeline control
//   instF, instF_valid, fault        registered fetch result
module imem_sync #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 1024,
   parameter int                ADDR_W    = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ld_we,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   input  logic                     ld_done,
   output logic                     ld_err,
   output logic                     ready,
   input  logic                     fetch_en,
   input  logic [ADDR_W-1:0]        pc,
   input  logic                     stall,
   input  logic                     flush,
   output logic [DATA_W-1:0]        instF,
   output logic                     instF_valid,
   output logic                     fault
);
   localparam int IDX_W = $clog2(DEPTH);
   // One extra bit so DEPTH*4 never overflows the compare width.
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH) << 2;

   typedef enum logic {LOAD, RUN} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic              run, legal, rd_en;

   assign run   = state_q == RUN;
   assign ready = run;
   // Full-width range check: high pc bits are never folded into the index.
   assign legal = pc[1:0] == 2'b00 && {1'b0, pc} < LIMIT;
   assign rd_en = run && !flush && !stall && fetch_en && legal;
   // The read register only advances on an accepted fetch, so a stall holds it;
   // the valid flag (reset/flush/fault/idle all clear it) selects the NOP.
   assign instF = instF_valid ? rd_q : NOP_INSTR;

   always_comb begin
      state_d = (state_q == LOAD && ld_done) ? RUN : state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         instF_valid <= 1'b0;
         fault       <= 1'b0;
         ld_err      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (run && ld_we) ld_err <= 1'b1;
         if (run && flush) begin
            instF_valid <= 1'b0;
            fault       <= 1'b0;
         end else if (run && !stall) begin
            instF_valid <= fetch_en && legal;
            fault       <= fetch_en && !legal;
         end
      end
   end

   // Block RAM: synchronous write in LOAD, synchronous read in RUN, no reset.
   always_ff @(posedge clk) begin
      if (!run && ld_we) mem[ld_addr] <= ld_data;
      if (rd_en) rd_q <= mem[pc[IDX_W+1:2]];
   end
endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed table-driven bench for imem_sync at default parameters.
module tb_imem_sync;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_we = 1'b0;
   logic [9:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        ld_done = 1'b0;
   logic        ld_err, ready;
   logic        fetch_en = 1'b0;
   logic [31:0] pc = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] instF;
   logic        instF_valid, fault;

   int total = 0;
   int bad = 0;

   imem_sync dut (
      .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_done(ld_done), .ld_err(ld_err), .ready(ready), .fetch_en(fetch_en), .pc(pc),
      .stall(stall), .flush(flush), .instF(instF), .instF_valid(instF_valid), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fe;
      logic [31:0] pc;
      logic        st;
      logic        fl;
      logic [31:0] ei;
      logic        ev;
      logic        ef;
   } vec_t;

   vec_t vec [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      step();
      ld_we = 1'b0;
   endtask

   initial begin
      vec[0]  = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h00500093, 1'b1, 1'b0};
      vec[1]  = '{1'b1, 32'h4,        1'b0, 1'b0, 32'h00A00113, 1'b1, 1'b0};
      vec[2]  = '{1'b1, 32'h8,        1'b0, 1'b0, 32'h002081B3, 1'b1, 1'b0};
      vec[3]  = '{1'b1, 32'hC,        1'b0, 1'b0, 32'h00000063, 1'b1, 1'b0};
      vec[4]  = '{1'b1, 32'h4,        1'b0, 1'b0, 32'h00A00113, 1'b1, 1'b0};
      vec[5]  = '{1'b1, 32'h8,        1'b1, 1'b0, 32'h00A00113, 1'b1, 1'b0};
      vec[6]  = '{1'b1, 32'hC,        1'b1, 1'b0, 32'h00A00113, 1'b1, 1'b0};
      vec[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h00A00113, 1'b1, 1'b0};
      vec[8]  = '{1'b1, 32'h8,        1'b1, 1'b1, NOP,          1'b0, 1'b0};
      vec[9]  = '{1'b1, 32'h6,        1'b0, 1'b0, NOP,          1'b0, 1'b1};
      vec[10] = '{1'b1, 32'h0,        1'b1, 1'b0, NOP,          1'b0, 1'b1};
      vec[11] = '{1'b1, 32'h0,        1'b0, 1'b1, NOP,          1'b0, 1'b0};
      vec[12] = '{1'b1, 32'h1000,     1'b0, 1'b0, NOP,          1'b0, 1'b1};
      vec[13] = '{1'b1, 32'hFFC,      1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0};
      vec[14] = '{1'b1, 32'h80000000, 1'b0, 1'b0, NOP,          1'b0, 1'b1};
      vec[15] = '{1'b0, 32'h4,        1'b0, 1'b0, NOP,          1'b0, 1'b0};
      vec[16] = '{1'b1, 32'h1004,     1'b0, 1'b0, NOP,          1'b0, 1'b1};

      step();
      step();
      chk("rst_instF", instF, NOP);
      chk("rst_valid", 32'(instF_valid), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_ld_err", 32'(ld_err), 0);
      rst_n = 1'b1;

      fetch_en = 1'b1; pc = 32'h0;
      step();
      step();
      chk("preboot_instF", instF, NOP);
      chk("preboot_valid", 32'(instF_valid), 0);
      chk("preboot_ready", 32'(ready), 0);
      fetch_en = 1'b0;

      load(10'd0, 32'h00500093);
      load(10'd1, 32'h00A00113);
      load(10'd2, 32'h002081B3);
      load(10'd3, 32'h00000063);
      ld_we = 1'b1; ld_addr = 10'd1023; ld_data = 32'h12345678; ld_done = 1'b1;
      chk("ready_before_done_edge", 32'(ready), 0);
      step();
      ld_we = 1'b0; ld_done = 1'b0;
      chk("ready_after_done", 32'(ready), 1);
      chk("ld_err_after_boot", 32'(ld_err), 0);

      for (int i = 0; i < 17; i++) begin
         fetch_en = vec[i].fe; pc = vec[i].pc; stall = vec[i].st; flush = vec[i].fl;
         step();
         chk($sformatf("vec%0d_instF", i), instF, vec[i].ei);
         chk($sformatf("vec%0d_valid", i), 32'(instF_valid), 32'(vec[i].ev));
         chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vec[i].ef));
      end
      fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;

      load(10'd0, 32'hDEADBEEF);
      chk("late_ld_err", 32'(ld_err), 1);
      fetch_en = 1'b1; pc = 32'h0;
      step();
      chk("late_no_write", instF, 32'h00500093);
      chk("late_valid", 32'(instF_valid), 1);
      step();
      chk("ld_err_sticky", 32'(ld_err), 1);

      pc = 32'h8;
      step();
      chk("pre_reset_instF", instF, 32'h002081B3);
      #3 rst_n = 1'b0;
      #1;
      chk("async_instF", instF, NOP);
      chk("async_valid", 32'(instF_valid), 0);
      chk("async_ready", 32'(ready), 0);
      chk("async_ld_err", 32'(ld_err), 0);
      #2 rst_n = 1'b1;
      step();
      chk("reload_ready", 32'(ready), 0);
      chk("reload_valid", 32'(instF_valid), 0);
      fetch_en = 1'b0; ld_done = 1'b1;
      step();
      ld_done = 1'b0;
      chk("reboot_ready", 32'(ready), 1);
      fetch_en = 1'b1; pc = 32'h8;
      step();
      chk("retained_instF", instF, 32'h002081B3);
      chk("retained_valid", 32'(instF_valid), 1);
      pc = 32'h0;
      step();
      chk("retained_word0", instF, 32'h00500093);
      fetch_en = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
